// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control/status bundle between the sequencer
// and its datapath (slave = sequencer, master = datapath side).
interface multicycle_sequencer_if;
    logic        run;
    logic [2:0]  instr_class;
    logic        ret_flag;
    logic        branch_taken;
    logic        mem_ready;
    logic [4:0]  stage;
    logic        ir_load;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        push;
    logic        pop;
    logic [3:0]  call_depth;
    logic        err_overflow;
    logic        err_underflow;
    logic [15:0] retired;

    modport master (
        output run, instr_class, ret_flag, branch_taken, mem_ready,
        input  stage, ir_load, reg_we, mem_rd, mem_wr, pc_we, pc_sel,
        input  push, pop, call_depth, err_overflow, err_underflow, retired
    );

    modport slave (
        input  run, instr_class, ret_flag, branch_taken, mem_ready,
        output stage, ir_load, reg_we, mem_rd, mem_wr, pc_we, pc_sel,
        output push, pop, call_depth, err_overflow, err_underflow, retired
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: IF/ID/EX/MEM/WB control FSM with an 8-deep return stack.
// Define SEQ_MEM_WAIT_EN to stall in MEM until mem_ready is sampled high.
module multicycle_sequencer (
    input  logic clk,
    input  logic reset,
    multicycle_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB
    } state_t;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_JUMP   = 3'd4;
    localparam logic [2:0] C_CALL   = 3'd5;
    localparam logic [2:0] C_CMP    = 3'd6;
    localparam logic [2:0] C_NOP    = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  cls_q;
    logic        ret_q;
    logic [4:0]  stage_q;
    logic        mem_rd_q, mem_wr_q;
    logic [3:0]  depth_q, depth_d;
    logic        ovf_q, unf_q;
    logic [15:0] retired_q;

    logic [2:0]  cls;
    logic        mem_done, last, is_call, want_pop;
    logic        push, pop, ovf_set, unf_set;
    logic [1:0]  pc_sel;

    // In ID the class comes straight from the decoder; afterwards only the latch.
    assign cls = (state_q == S_ID) ? bus.instr_class : cls_q;

`ifdef SEQ_MEM_WAIT_EN
    assign mem_done = bus.mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    always_comb begin
        last = 1'b0;
        case (state_q)
            S_ID:  last = (cls == C_JUMP) || (cls == C_CALL) || (cls == C_NOP);
            S_EX:  last = (cls == C_BRANCH) || (cls == C_CMP);
            S_MEM: last = (cls == C_STORE) && mem_done;
            S_WB:  last = 1'b1;
            default: last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = bus.run ? S_IF : S_IDLE;
            S_IF:   state_d = S_ID;
            S_ID:   state_d = S_EX;
            S_EX:   state_d = ((cls == C_LOAD) || (cls == C_STORE)) ? S_MEM : S_WB;
            S_MEM:  state_d = mem_done ? S_WB : S_MEM;
            default: state_d = S_IDLE;
        endcase
        if (last) state_d = bus.run ? S_IF : S_IDLE;
    end

    assign is_call  = last && (state_q == S_ID) && (cls == C_CALL);
    assign push     = is_call && (depth_q < 4'd8);
    assign ovf_set  = is_call && (depth_q >= 4'd8);
    assign want_pop = last && ret_q &&
                      ((cls == C_ALU) || (cls == C_LOAD) || (cls == C_STORE));
    assign pop      = want_pop && (depth_q != 4'd0);
    assign unf_set  = want_pop && (depth_q == 4'd0);
    assign depth_d  = depth_q + {3'b000, push} - {3'b000, pop};

    always_comb begin
        pc_sel = 2'b00;
        if (last) begin
            if ((cls == C_JUMP) || (cls == C_CALL)) pc_sel = 2'b01;
            else if (cls == C_BRANCH)               pc_sel = {bus.branch_taken, 1'b0};
            else if (pop)                           pc_sel = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ALU;
            ret_q     <= 1'b0;
            stage_q   <= 5'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            depth_q   <= 4'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                cls_q <= bus.instr_class;
                ret_q <= bus.ret_flag;
            end
            stage_q   <= {state_d == S_WB, state_d == S_MEM, state_d == S_EX,
                          state_d == S_ID, state_d == S_IF};
            mem_rd_q  <= (state_d == S_MEM) && (cls == C_LOAD);
            mem_wr_q  <= (state_d == S_MEM) && (cls == C_STORE);
            depth_q   <= depth_d;
            ovf_q     <= ovf_q | ovf_set;
            unf_q     <= unf_q | unf_set;
            retired_q <= retired_q + {15'd0, last};
        end
    end

    assign bus.stage         = stage_q;
    assign bus.ir_load       = stage_q[0];
    assign bus.reg_we        = stage_q[4];
    assign bus.mem_rd        = mem_rd_q;
    assign bus.mem_wr        = mem_wr_q;
    assign bus.pc_we         = last;
    assign bus.pc_sel        = pc_sel;
    assign bus.push          = push;
    assign bus.pop           = pop;
    assign bus.call_depth    = depth_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table-driven instruction vectors plus hand
// sequences for return-stack limits, counter wrap, MEM wait and reset abort.
module tb_multicycle_sequencer;
    localparam logic [4:0] SIF = 5'b00001;
    localparam logic [4:0] SID = 5'b00010;
    localparam logic [4:0] SEX = 5'b00100;
    localparam logic [4:0] SMM = 5'b01000;
    localparam logic [4:0] SWB = 5'b10000;
    localparam logic [4:0] Z   = 5'b00000;

    localparam logic [24:0] Q_ALU = {Z, SWB, SEX, SID, SIF};
    localparam logic [24:0] Q_LD  = {SWB, SMM, SEX, SID, SIF};
    localparam logic [24:0] Q_ST  = {Z, SMM, SEX, SID, SIF};
    localparam logic [24:0] Q_BR  = {Z, Z, SEX, SID, SIF};
    localparam logic [24:0] Q_J   = {Z, Z, Z, SID, SIF};

`ifdef SEQ_MEM_WAIT_EN
    localparam logic MR = 1'b1;
`else
    localparam logic MR = 1'b0;
`endif

    typedef struct {
        logic [2:0]  cls;
        logic        ret;
        logic        taken;
        int          len;
        logic [24:0] seq;
        logic [1:0]  sel;
        logic        we, rd, wr, push, pop;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [15:0] exp_ret;
    logic [3:0] exp_depth;

    multicycle_sequencer_if bus ();

    multicycle_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(logic [2:0] cls, logic ret, logic taken,
                                 int len, logic [24:0] seq, logic [1:0] sel,
                                 logic we, logic rd, logic wr,
                                 logic push, logic pop);
        vec_t v;
        v.cls = cls; v.ret = ret; v.taken = taken; v.len = len; v.seq = seq;
        v.sel = sel; v.we = we; v.rd = rd; v.wr = wr; v.push = push; v.pop = pop;
        return v;
    endfunction

    function automatic logic [13:0] obs();
        return {bus.stage, bus.ir_load, bus.reg_we, bus.mem_rd, bus.mem_wr,
                bus.pc_we, bus.pc_sel, bus.push, bus.pop};
    endfunction

    function automatic logic [13:0] expo(vec_t v, int c);
        logic [4:0] st;
        logic lst;
        st  = v.seq[5*c +: 5];
        lst = (c == v.len - 1);
        return {st, c == 0, lst && v.we, (st == SMM) && v.rd,
                (st == SMM) && v.wr, lst, lst ? v.sel : 2'b00,
                lst && v.push, lst && v.pop};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_strobes", {18'd0, obs()}, 32'd0);
        chk("reset_status", {bus.call_depth, bus.err_overflow,
                             bus.err_underflow, bus.retired}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 16'd0;
        exp_depth = 4'd0;
    endtask

    task automatic run_one(input string name, input vec_t v, input logic mr);
        bus.instr_class  = v.cls;
        bus.ret_flag     = v.ret;
        bus.branch_taken = v.taken;
        bus.mem_ready    = mr;
        bus.run          = 1'b1;
        @(posedge clk);
        #1 bus.run = 1'b0;
        #1 chk({name, "_c0"}, {18'd0, obs()}, {18'd0, expo(v, 0)});
        for (int c = 1; c < v.len; c++) begin
            @(posedge clk);
            #1;
            if (c >= 2) begin
                bus.instr_class = ~v.cls;
                bus.ret_flag    = ~v.ret;
            end
            #1 chk($sformatf("%s_c%0d", name, c), {18'd0, obs()},
                   {18'd0, expo(v, c)});
        end
        exp_ret   = exp_ret + 16'd1;
        exp_depth = exp_depth + {3'd0, v.push} - {3'd0, v.pop};
        @(posedge clk);
        #2;
        chk({name, "_idle"}, {18'd0, obs()}, 32'd0);
        chk({name, "_retired"}, {16'd0, bus.retired}, {16'd0, exp_ret});
        chk({name, "_depth"}, {28'd0, bus.call_depth}, {28'd0, exp_depth});
    endtask

    vec_t tbl [9];
    vec_t vcall, vst;
    logic [13:0] wexp;

    initial begin
        bus.run = 1'b0; bus.instr_class = 3'd0; bus.ret_flag = 1'b0;
        bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;

        tbl[0] = mkv(3'd0, 1'b0, 1'b0, 4, Q_ALU, 2'b00, 1, 0, 0, 0, 0);
        tbl[1] = mkv(3'd1, 1'b0, 1'b0, 5, Q_LD,  2'b00, 1, 1, 0, 0, 0);
        tbl[2] = mkv(3'd2, 1'b0, 1'b0, 4, Q_ST,  2'b00, 0, 0, 1, 0, 0);
        tbl[3] = mkv(3'd3, 1'b0, 1'b1, 3, Q_BR,  2'b10, 0, 0, 0, 0, 0);
        tbl[4] = mkv(3'd3, 1'b0, 1'b0, 3, Q_BR,  2'b00, 0, 0, 0, 0, 0);
        tbl[5] = mkv(3'd6, 1'b0, 1'b1, 3, Q_BR,  2'b00, 0, 0, 0, 0, 0);
        tbl[6] = mkv(3'd4, 1'b1, 1'b0, 2, Q_J,   2'b01, 0, 0, 0, 0, 0);
        tbl[7] = mkv(3'd7, 1'b1, 1'b0, 2, Q_J,   2'b00, 0, 0, 0, 0, 0);
        tbl[8] = mkv(3'd3, 1'b1, 1'b1, 3, Q_BR,  2'b10, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 9; i++)
            run_one($sformatf("vec%0d", i), tbl[i], MR);
        chk("no_err_after_table", {30'd0, bus.err_overflow, bus.err_underflow}, 32'd0);

        // counter wrap
        @(negedge clk);
        force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        exp_ret = 16'hFFFF;
        run_one("br_wrap", tbl[3], MR);
        run_one("br_after_wrap", tbl[4], MR);

        // return-stack underflow then a real pop
        do_reset();
        vst = mkv(3'd2, 1'b1, 1'b0, 4, Q_ST, 2'b00, 0, 0, 1, 0, 0);
        run_one("st_unf", vst, MR);
        chk("err_underflow", {31'd0, bus.err_underflow}, 32'd1);
        vcall = mkv(3'd5, 1'b0, 1'b0, 2, Q_J, 2'b01, 0, 0, 0, 1, 0);
        run_one("call_a", vcall, MR);
        run_one("call_b", vcall, MR);
        vst = mkv(3'd2, 1'b1, 1'b0, 4, Q_ST, 2'b11, 0, 0, 1, 0, 1);
        run_one("st_pop", vst, MR);
        chk("unf_sticky", {31'd0, bus.err_underflow}, 32'd1);

        // nine calls: eighth fills the stack, ninth overflows
        do_reset();
        for (int i = 0; i < 9; i++) begin
            vcall = mkv(3'd5, 1'b1, 1'b0, 2, Q_J, 2'b01, 0, 0, 0, i < 8, 0);
            run_one($sformatf("call%0d", i), vcall, MR);
            chk($sformatf("ovf%0d", i), {31'd0, bus.err_overflow},
                {31'd0, i == 8});
        end

`ifdef SEQ_MEM_WAIT_EN
        do_reset();
        bus.instr_class = 3'd1; bus.ret_flag = 1'b0; bus.mem_ready = 1'b0;
        bus.run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            bus.run = 1'b0;
            bus.mem_ready = (c == 7);
            if (c < 4)      wexp = {5'b00001 << (c - 1), c == 1, 8'b0};
            else if (c < 8) wexp = {SMM, 3'b001, 6'b0};
            else            wexp = {SWB, 2'b01, 2'b00, 1'b1, 4'b0};
            #1 chk($sformatf("ldwait_c%0d", c), {18'd0, obs()}, {18'd0, wexp});
        end
        @(posedge clk);
        #2 chk("ldwait_retired", {16'd0, bus.retired}, 32'd1);
`else
        run_one("ld_ignore_ready", tbl[1], 1'b0);
`endif

        // reset in MEM of a LOAD aborts it
        do_reset();
        bus.instr_class = 3'd1; bus.ret_flag = 1'b0; bus.mem_ready = 1'b0;
        bus.run = 1'b1;
        @(posedge clk);
        #1 bus.run = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("rst_mem_before", {18'd0, obs()}, {18'd0, SMM, 3'b001, 6'b0});
        #1 reset = 1'b1;
        #1 chk("rst_mem_now", {18'd0, obs()}, 32'd0);
        chk("rst_mem_status", {bus.call_depth, bus.err_overflow,
                               bus.err_underflow, bus.retired}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2 chk($sformatf("rst_after%0d", c),
                   {2'd0, obs(), bus.retired}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have clk  in  1  rising-edge clock.
REQ-002 SHALL have reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have run  in  1  level; 1 = fetch new instructions, 0 = stop after current instruction.
REQ-004 SHALL have instr_class  in  3  decoded class, valid in ID cycle: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 CALL, 6 CMP, 7 NOP.
REQ-005 SHALL have ret_flag  in  1  instruction pop bit, valid in ID cycle.
REQ-006 SHALL have branch_taken  in  1  ALU zero result, valid in EX cycle.
REQ-007 SHALL have mem_ready  in  1  data memory done, sampled in MEM cycles.
REQ-008 SHALL have stage  out  5  one-hot {WB,MEM,EX,ID,IF}; 0 in IDLE.
REQ-009 SHALL have ir_load  out  1, reg_we  out  1, mem_rd  out  1, mem_wr  out  1  datapath strobes.
REQ-010 SHALL have pc_we  out  1, pc_sel  out  2  (00 PC+1, 01 PC+imm24, 10 PC+imm14, 11 stack top+1).
REQ-011 SHALL have push  out  1, pop  out  1, call_depth  out  4  return-stack control and occupancy.
REQ-012 SHALL have err_overflow  out  1, err_underflow  out  1  sticky error flags.
REQ-013 SHALL have retired  out  16  retired-instruction counter.

Function
REQ-014 SHALL implement states IDLE, IF, ID, EX, MEM, WB; IDLE->IF when run=1, else stay IDLE.
REQ-015 SHALL sequence per class: ALU IF-ID-EX-WB; LOAD IF-ID-EX-MEM-WB; STORE IF-ID-EX-MEM; BRANCH/CMP IF-ID-EX; JUMP/CALL/NOP IF-ID.
REQ-016 SHALL latch instr_class and ret_flag at end of ID; later stages use latched values only.
REQ-017 SHALL assert ir_load exactly in IF cycle; reg_we exactly in WB cycle.
REQ-018 SHALL hold mem_rd (LOAD) or mem_wr (STORE) high for every MEM cycle, never both.
REQ-019 SHALL pulse pc_we for one cycle in the last stage of each instruction, with pc_sel valid same cycle.
REQ-020 SHALL drive pc_sel: JUMP/CALL 01; BRANCH 10 if branch_taken else 00; CMP/NOP 00; ALU/LOAD/STORE 11 if popping else 00.
REQ-021 SHALL, for CALL in ID: if call_depth<8 pulse push and increment depth; if depth=8 set err_overflow, no push, still pc_sel=01.
REQ-022 SHALL, for ALU/LOAD/STORE with latched ret_flag in final stage: if depth>0 pulse pop, decrement depth, pc_sel=11; if depth=0 set err_underflow, no pop, pc_sel=00.
REQ-023 SHALL ignore ret_flag for BRANCH, CMP, JUMP, CALL, NOP.
REQ-024 SHALL never assert push and pop in the same cycle.
REQ-025 SHALL, after last stage, go to IF if run=1 else IDLE; run falling mid-instruction completes that instruction.
REQ-026 SHALL increment retired on every pc_we, wrapping 0xFFFF->0x0000.
REQ-027 SHALL give latencies IF-to-pc_we: 2 cycles JUMP/CALL/NOP, 3 BRANCH/CMP, 4 ALU/STORE, 5 LOAD (plus wait cycles, REQ-031).

Reset
REQ-028 SHALL on reset asynchronously enter IDLE and clear stage, all strobes, pc_sel, call_depth, error flags, retired to 0.
REQ-029 SHALL abort any in-flight instruction on reset with no pc_we, push, pop, reg_we or memory strobe after assertion.
REQ-030 SHALL leave IDLE no earlier than the first rising clk edge after reset deasserts with run=1.

Configuration
REQ-031 SHALL, with SEQ_MEM_WAIT_EN defined, stay in MEM until mem_ready=1 is sampled (unbounded), strobe held throughout.
REQ-032 SHALL, without SEQ_MEM_WAIT_EN, spend exactly one cycle in MEM and ignore mem_ready.

Verification
REQ-033 SHALL test ALU class, run=1: stage IF,ID,EX,WB; reg_we in cycle 4; pc_we cycle 4, pc_sel=00; retired 0->1.
REQ-034 SHALL test LOAD with SEQ_MEM_WAIT_EN, mem_ready low 3 MEM cycles: mem_rd high 4 cycles, pc_we in cycle 8.
REQ-035 SHALL test 9 consecutive CALLs: push on first 8, call_depth=8, 9th sets err_overflow, no push, pc_sel=01.
REQ-036 SHALL test STORE with ret_flag=1 at depth 0: mem_wr 1 cycle, no pop, err_underflow=1, pc_sel=00; at depth 2: pop, depth 1, pc_sel=11.
REQ-037 SHALL test BRANCH taken/not taken: pc_we cycle 3 with pc_sel 10 / 00; retired preset 0xFFFF wraps to 0x0000.
REQ-038 SHALL test reset asserted in MEM cycle of LOAD: immediate IDLE, all outputs 0, no pc_we/reg_we afterwards.
